// File: rtl/tetris_pkg.sv
// tetris_pkg: shared types and constants for the falling-piece controller.
//   state_e     - controller FSM states
//   piece_e     - tetromino type codes I,O,T,S,Z,J,L = 0..6
//   SPRITE_SIZE - piece sprite edge length in pixels
//   TYPE_W/ROT_W/CTRL_W - widths of the ctrl output fields
package tetris_pkg;

  localparam int unsigned SPRITE_SIZE = 32;
  localparam int unsigned TYPE_W      = 3;
  localparam int unsigned ROT_W       = 2;
  localparam int unsigned CTRL_W      = TYPE_W + ROT_W;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StFall = 2'd1,
    StLand = 2'd2
  } state_e;

  typedef enum logic [TYPE_W-1:0] {
    PieceI = 3'd0,
    PieceO = 3'd1,
    PieceT = 3'd2,
    PieceS = 3'd3,
    PieceZ = 3'd4,
    PieceJ = 3'd5,
    PieceL = 3'd6
  } piece_e;

endpackage

// File: rtl/grav_timer.sv
// grav_timer: modulo-Div counter producing the gravity step.
//   clk_i   - clock
//   reset_i - synchronous active-high reset (count to 0)
//   en_i    - count enable
//   clr_i   - synchronous clear, wins over counting
//   tick_o  - high for the cycle the count sits at Div-1 while enabled
module grav_timer #(
  parameter int unsigned Div = 4
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic en_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int unsigned CntW = $clog2(Div);
  localparam logic [CntW-1:0] Last = CntW'(Div - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign tick_o = en_i && (cnt_q == Last);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = (cnt_q == Last) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/block_ctrl.sv
// block_ctrl: position/rotation controller for one falling piece.
// Optional feature: define BLOCK_CTRL_HARD_DROP_EN to enable btn_drop.
// Ports:
//   clk, reset (sync, active-high)
//   start, new_type[2:0]               - spawn a piece (type 7 maps to 0)
//   btn_left/right/rot/down/drop       - single-cycle button pulses
//   x0[10:0], y0[10:0]                 - sprite origin in pixels
//   ctrl[4:0] = {type, rot}, visible   - sprite select / draw enable
//   busy (state FALL), landed (one-cycle pulse in LAND)
module block_ctrl
  import tetris_pkg::*;
#(
  parameter int unsigned X_MIN    = 160,
  parameter int unsigned X_MAX    = 480,
  parameter int unsigned Y_TOP    = 0,
  parameter int unsigned Y_BOT    = 480,
  parameter int unsigned X_SPAWN  = 304,
  parameter int unsigned STEP     = 8,
  parameter int unsigned GRAV_DIV = 25_000_000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [2:0]        new_type,
  input  logic              btn_left,
  input  logic              btn_right,
  input  logic              btn_rot,
  input  logic              btn_down,
  input  logic              btn_drop,
  output logic [10:0]       x0,
  output logic [10:0]       y0,
  output logic [CTRL_W-1:0] ctrl,
  output logic              visible,
  output logic              busy,
  output logic              landed
);

  localparam logic [10:0] XMin   = 11'(X_MIN);
  localparam logic [10:0] XMax   = 11'(X_MAX);
  localparam logic [10:0] YTop   = 11'(Y_TOP);
  localparam logic [10:0] YBot   = 11'(Y_BOT);
  localparam logic [10:0] XSpawn = 11'(X_SPAWN);
  localparam logic [10:0] Step   = 11'(STEP);
  localparam logic [10:0] Spr    = 11'(SPRITE_SIZE);
  localparam logic [10:0] YDrop  = 11'(Y_BOT - SPRITE_SIZE);

  state_e           state_q, state_d;
  logic [10:0]      x0_q, x0_d, y0_q, y0_d;
  piece_e           type_q, type_d;
  logic [ROT_W-1:0] rot_q, rot_d;
  logic             vis_q, vis_d;
  // Set in the hard-drop cycle; forces LAND on the following edge.
  logic             pend_q, pend_d;
  logic             grav_tick, grav_clr, grav_en, drop_req, land;

`ifdef BLOCK_CTRL_HARD_DROP_EN
  assign drop_req = btn_drop;
`else
  logic unused_btn_drop;
  assign unused_btn_drop = btn_drop;
  assign drop_req        = 1'b0;
`endif

  assign grav_en = (state_q == StFall);

  grav_timer #(
    .Div (GRAV_DIV)
  ) u_grav_timer (
    .clk_i   (clk),
    .reset_i (reset),
    .en_i    (grav_en),
    .clr_i   (grav_clr),
    .tick_o  (grav_tick)
  );

  always_comb begin
    state_d  = state_q;
    x0_d     = x0_q;
    y0_d     = y0_q;
    type_d   = type_q;
    rot_d    = rot_q;
    vis_d    = vis_q;
    pend_d   = 1'b0;
    grav_clr = 1'b0;
    land     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d  = StFall;
          x0_d     = XSpawn;
          y0_d     = YTop;
          type_d   = (new_type == 3'd7) ? PieceI : piece_e'(new_type);
          rot_d    = '0;
          vis_d    = 1'b1;
          grav_clr = 1'b1;
        end
      end
      StFall: begin
        grav_clr = btn_down;
        if (pend_q) begin
          state_d = StLand;
        end else if (drop_req) begin
          y0_d   = YDrop;
          pend_d = 1'b1;
        end else begin
          // Gravity and soft drop merge into a single step.
          if (grav_tick || btn_down) begin
            if (y0_q + Step + Spr <= YBot) begin
              y0_d = y0_q + Step;
            end else begin
              land    = 1'b1;
              state_d = StLand;
            end
          end
          if (!land) begin
            if (btn_left && !btn_right && (x0_q >= XMin + Step)) begin
              x0_d = x0_q - Step;
            end else if (btn_right && !btn_left && (x0_q + Step + Spr <= XMax)) begin
              x0_d = x0_q + Step;
            end
            if (btn_rot) begin
              rot_d = rot_q + 2'd1;
            end
          end
        end
      end
      StLand: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      x0_q    <= XSpawn;
      y0_q    <= YTop;
      type_q  <= PieceI;
      rot_q   <= '0;
      vis_q   <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x0_q    <= x0_d;
      y0_q    <= y0_d;
      type_q  <= type_d;
      rot_q   <= rot_d;
      vis_q   <= vis_d;
      pend_q  <= pend_d;
    end
  end

  assign x0      = x0_q;
  assign y0      = y0_q;
  assign ctrl    = {type_q, rot_q};
  assign visible = vis_q;
  assign busy    = (state_q == StFall);
  assign landed  = (state_q == StLand);

endmodule

// File: tb/tb_block_ctrl.sv
// tb_block_ctrl: table vectors, directed corner sequences and randomized stimulus
// checked against a behavioural model of block_ctrl (GRAV_DIV = 4).
module tb_block_ctrl;

  localparam int GD = 4;
`ifdef BLOCK_CTRL_HARD_DROP_EN
  localparam bit Hard = 1'b1;
`else
  localparam bit Hard = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0, start = 1'b0;
  logic [2:0]  new_type = 3'd0;
  logic        btn_left = 1'b0, btn_right = 1'b0, btn_rot = 1'b0;
  logic        btn_down = 1'b0, btn_drop = 1'b0;
  logic [10:0] x0, y0;
  logic [4:0]  ctrl;
  logic        visible, busy, landed;

  block_ctrl #(
    .GRAV_DIV (GD)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .new_type  (new_type),
    .btn_left  (btn_left),
    .btn_right (btn_right),
    .btn_rot   (btn_rot),
    .btn_down  (btn_down),
    .btn_drop  (btn_drop),
    .x0        (x0),
    .y0        (y0),
    .ctrl      (ctrl),
    .visible   (visible),
    .busy      (busy),
    .landed    (landed)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: mode 0 idle, 1 falling, 2 landed.
  int m_mode = 0, m_x = 304, m_y = 0, m_ty = 0, m_rot = 0, m_phase = 0;
  bit m_vis = 0, m_pend = 0;

  task automatic model(input bit rs, st, input int ty, input bit l, r, ro, dn, dp);
    bit tick;
    if (rs) begin
      m_mode = 0; m_x = 304; m_y = 0; m_ty = 0; m_rot = 0; m_phase = 0;
      m_vis = 0; m_pend = 0;
    end else if (m_mode == 2) begin
      m_mode = 0;
    end else if (m_mode == 0) begin
      if (st) begin
        m_mode = 1; m_x = 304; m_y = 0; m_ty = (ty == 7) ? 0 : ty; m_rot = 0;
        m_vis = 1; m_phase = 0;
      end
    end else begin
      tick = (m_phase == GD - 1);
      m_phase = dn ? 0 : (m_phase + 1) % GD;
      if (m_pend) begin
        m_pend = 0;
        m_mode = 2;
      end else if (Hard && dp) begin
        m_y = 480 - 32;
        m_pend = 1;
      end else begin
        if (tick || dn) begin
          if (m_y + 8 + 32 <= 480) m_y += 8;
          else m_mode = 2;
        end
        if (m_mode == 1) begin
          if (l && !r && m_x - 8 >= 160) m_x -= 8;
          if (r && !l && m_x + 8 + 32 <= 480) m_x += 8;
          if (ro) m_rot = (m_rot + 1) % 4;
        end
      end
    end
  endtask

  task automatic cyc(input logic rs, st, input logic [2:0] ty,
                     input logic l, r, ro, dn, dp);
    reset = rs; start = st; new_type = ty; btn_left = l; btn_right = r;
    btn_rot = ro; btn_down = dn; btn_drop = dp;
    @(posedge clk);
    #1;
    model(rs, st, int'(ty), l, r, ro, dn, dp);
    chk("mdl_x0", x0, m_x);
    chk("mdl_y0", y0, m_y);
    chk("mdl_ctrl", ctrl, m_ty * 4 + m_rot);
    chk("mdl_visible", visible, m_vis);
    chk("mdl_busy", busy, m_mode == 1);
    chk("mdl_landed", landed, m_mode == 2);
  endtask

  task automatic idle1();
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  typedef struct {
    logic       rs, st;
    logic [2:0] ty;
    logic       l, r, ro, dn, dp;
    int         ex, ey;
    logic [4:0] ec;
    logic       ev, eb, el;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic rs, st, logic [2:0] ty, logic l, r, ro, dn, dp,
                              int ex, ey, logic [4:0] ec, logic ev, eb, el);
    vec_t v;
    v.rs = rs; v.st = st; v.ty = ty; v.l = l; v.r = r; v.ro = ro; v.dn = dn; v.dp = dp;
    v.ex = ex; v.ey = ey; v.ec = ec; v.ev = ev; v.eb = eb; v.el = el;
    return v;
  endfunction

  initial begin
    int n;
    bit seen;

    //           rs st ty l  r  ro dn dp   x    y   ctrl      v  b  l
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 304, 0, 5'b00000, 0, 0, 0));
    tbl.push_back(mk(0, 1, 2, 0, 0, 0, 0, 0, 304, 0, 5'b01000, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 304, 0, 5'b01001, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 296, 0, 5'b01001, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0, 296, 0, 5'b01001, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 296, 8, 5'b01001, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 296, 16, 5'b01001, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 304, 16, 5'b01001, 1, 1, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 304, 0, 5'b00000, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 1, 1, 0, 304, 0, 5'b00000, 0, 0, 0));
    tbl.push_back(mk(0, 1, 7, 0, 0, 0, 0, 0, 304, 0, 5'b00000, 1, 1, 0));
    tbl.push_back(mk(1, 1, 3, 1, 0, 0, 0, 0, 304, 0, 5'b00000, 0, 0, 0));
    tbl.push_back(mk(0, 1, 6, 0, 0, 0, 0, 0, 304, 0, 5'b11000, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 304, 0, 5'b11001, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 304, 0, 5'b11010, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 304, 0, 5'b11011, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 304, 8, 5'b11000, 1, 1, 0));
    tbl.push_back(mk(0, 1, 3, 0, 0, 0, 0, 0, 304, 8, 5'b11000, 1, 1, 0));
    if (Hard) begin
      tbl.push_back(mk(0, 0, 0, 1, 0, 1, 0, 1, 304, 448, 5'b11000, 1, 1, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 304, 448, 5'b11000, 1, 0, 1));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 304, 448, 5'b11000, 1, 0, 0));
    end else begin
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 304, 8, 5'b11000, 1, 1, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 304, 8, 5'b11000, 1, 1, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 304, 16, 5'b11000, 1, 1, 0));
    end

    for (int i = 0; i < tbl.size(); i++) begin
      cyc(tbl[i].rs, tbl[i].st, tbl[i].ty, tbl[i].l, tbl[i].r, tbl[i].ro,
          tbl[i].dn, tbl[i].dp);
      chk($sformatf("vec%0d_x0", i), x0, tbl[i].ex);
      chk($sformatf("vec%0d_y0", i), y0, tbl[i].ey);
      chk($sformatf("vec%0d_ctrl", i), ctrl, tbl[i].ec);
      chk($sformatf("vec%0d_visible", i), visible, tbl[i].ev);
      chk($sformatf("vec%0d_busy", i), busy, tbl[i].eb);
      chk($sformatf("vec%0d_landed", i), landed, tbl[i].el);
    end

    // Free fall to the floor: 56 steps of 4 cycles, landing on the next tick.
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 2, 0, 0, 0, 0, 0);
    for (int k = 0; k < 224; k++) idle1();
    chk("fall_y_bottom", y0, 448);
    chk("fall_busy_bottom", busy, 1);
    n = 0;
    seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      idle1();
      n++;
      if (landed === 1'b1) seen = 1;
    end
    chk("fall_land_seen", seen, 1);
    chk("fall_land_cycles", n, 4);
    chk("fall_land_y", y0, 448);
    idle1();
    chk("post_land_landed", landed, 0);
    chk("post_land_busy", busy, 0);
    chk("post_land_y", y0, 448);
    chk("post_land_visible", visible, 1);

    // Horizontal walls.
    cyc(0, 1, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 20; k++) cyc(0, 0, 0, 1, 0, 0, 0, 0);
    chk("wall_left", x0, 160);
    for (int k = 0; k < 40; k++) cyc(0, 0, 0, 0, 1, 0, 0, 0);
    chk("wall_right", x0, 448);
    cyc(0, 0, 0, 1, 1, 0, 0, 0);
    chk("wall_both", x0, 448);

    // Reset in the middle of a fall.
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 5, 0, 0, 0, 0, 0);
    for (int k = 0; k < 150 && y0 !== 11'd200; k++) idle1();
    chk("mid_y200", y0, 200);
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_visible", visible, 0);
    chk("mid_rst_ctrl", ctrl, 0);
    chk("mid_rst_y", y0, 0);
    for (int k = 0; k < 3; k++) begin
      idle1();
      chk("mid_rst_landed", landed, 0);
    end

    // Hard drop from y0=16.
    cyc(0, 1, 1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 8; k++) idle1();
    chk("drop_pre_y", y0, 16);
    cyc(0, 0, 0, 0, 0, 0, 0, 1);
    chk("drop_y", y0, Hard ? 448 : 16);
    chk("drop_busy", busy, 1);
    idle1();
    chk("drop_landed", landed, Hard ? 1 : 0);

    // Randomized run against the model.
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 3000; k++) begin
      cyc($urandom_range(0, 199) == 0, $urandom_range(0, 9) == 0,
          3'($urandom_range(0, 7)), $urandom_range(0, 4) == 0,
          $urandom_range(0, 4) == 0, $urandom_range(0, 6) == 0,
          $urandom_range(0, 19) == 0, $urandom_range(0, 49) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/block_ctrl.md
BLOCK_CTRL -- requirements
Module: block_ctrl

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- X_MIN, 160: playfield left edge (px).
- X_MAX, 480: playfield right edge, exclusive (px).
- Y_TOP, 0: spawn row (px).
- Y_BOT, 480: playfield bottom, exclusive (px).
- X_SPAWN, 304: spawn column (px).
- STEP, 8: move granularity (px).
- GRAV_DIV, 25_000_000: clk cycles per gravity step (≥2).

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1: sole clock.
- reset, in, 1: synchronous, active-high.
- start, in, 1: spawn-piece pulse.
- new_type, in, 3: piece type 0..6; value 7 is treated as 0.
- btn_left, in, 1: move-left pulse.
- btn_right, in, 1: move-right pulse.
- btn_rot, in, 1: rotate pulse.
- btn_down, in, 1: soft-drop pulse.
- btn_drop, in, 1: hard-drop pulse.
- x0, out, 11: sprite origin x (px).
- y0, out, 11: sprite origin y (px).
- ctrl, out, 5: {type[2:0], rot[1:0]}, drives the sprite source select.
- visible, out, 1: piece is drawn.
- busy, out, 1: high while in FALL.
- landed, out, 1: one-cycle landing pulse.

Function
REQ-003 The FSM SHALL have states IDLE, FALL, LAND; all outputs SHALL be registered and update on the clk edge after the causing input, giving 1-cycle latency.
REQ-004 IDLE + start SHALL load x0=X_SPAWN, y0=Y_TOP, type=new_type, rot=0, visible=1, clear the gravity counter, and go to FALL.
REQ-005 start SHALL be ignored in FALL and LAND.
REQ-006 In FALL, the gravity counter SHALL count 0..GRAV_DIV-1 and issue a step on its terminal count, then wrap to 0.
REQ-007 A step (gravity or btn_down) SHALL add STEP to y0 if y0+STEP+32 ≤ Y_BOT; otherwise the FSM SHALL go to LAND with y0 unchanged.
REQ-008 btn_down SHALL clear the gravity counter.
REQ-009 btn_left SHALL subtract STEP from x0 only if x0-STEP ≥ X_MIN; otherwise x0 is held.
REQ-010 btn_right SHALL add STEP to x0 only if x0+STEP+32 ≤ X_MAX; otherwise x0 is held.
REQ-011 btn_rot SHALL set rot=(rot+1) mod 4, wrapping 3→0, and is always legal.
REQ-012 Same-cycle events SHALL be resolved as follows:
- Vertical (step/drop) and horizontal and rotate actions apply together in the same cycle.
- Horizontal bounds are checked against the pre-cycle x0.
- btn_left together with btn_right SHALL produce no horizontal move.
- A gravity step coinciding with btn_down SHALL move y0 by one STEP only.
- Landing SHALL suppress horizontal moves and rotation in that cycle.
REQ-013 LAND SHALL last exactly 1 cycle with landed=1, then go to IDLE; x0, y0, ctrl and visible SHALL hold until the next start.
REQ-014 busy SHALL be 1 exactly when state=FALL.
REQ-015 All button inputs SHALL be ignored outside FALL.

Reset
REQ-016 reset SHALL force, on the next clk edge, state=IDLE, x0=X_SPAWN, y0=Y_TOP, ctrl=0, visible=0, busy=0, landed=0, gravity counter=0.
REQ-017 reset SHALL take priority over all other inputs, including mid-FALL and during LAND.

Configuration
REQ-018 With BLOCK_CTRL_HARD_DROP_EN defined, btn_drop in FALL SHALL set y0 to Y_BOT-32 in one cycle and go to LAND on the next edge.
REQ-019 btn_drop SHALL take priority over step, horizontal moves and rotation in the same cycle.
REQ-020 Without BLOCK_CTRL_HARD_DROP_EN, the btn_drop port SHALL remain present but be ignored.

Structure
REQ-021 Package tetris_pkg SHALL hold the state enum, the piece-type enum (I,O,T,S,Z,J,L = 0..6), SPRITE_SIZE=32 and the ctrl field widths.
REQ-022 The gravity counter SHALL be a sub-module grav_timer (mod-GRAV_DIV counter with clear input and one-cycle tick output).

Verification (GRAV_DIV=4 unless noted)
REQ-023 reset, then start with new_type=2 → next cycle: x0=304, y0=0, ctrl=5'b01000, visible=1, busy=1.
REQ-024 No buttons after spawn → y0 increments by 8 every 4 cycles; after 56 steps y0=448; next tick → landed=1 for one cycle, then IDLE, y0 still 448.
REQ-025 x0=160 + btn_left → x0 stays 160; x0=448 + btn_right → x0 stays 448; btn_left and btn_right together at x0=304 → x0 stays 304.
REQ-026 Four btn_rot pulses with type=6 → ctrl sequence 11001, 11010, 11011, 11000.
REQ-027 With the macro defined, btn_drop at y0=16 → y0=448 next cycle, landed=1 on the following cycle; without the macro, btn_drop has no effect.
REQ-028 reset asserted mid-FALL at y0=200 → next cycle: IDLE, visible=0, ctrl=0, y0=0, and no landed pulse.
